// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: synchronise, debounce and decode A/B into a signed
// position counter, plus a debounced push button with a press strobe.

module qed_debounce #(
   parameter int W          = 1,
   parameter int DEB_CYCLES = 4,
   parameter bit PRIME      = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] filt_o,
   output logic [W-1:0] prev_o,
   output logic         upd_o
);
   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic [W-1:0]  s1_q, s2_q, s3_q;
   logic [W-1:0]  filt_q, filt_d;
   logic [W-1:0]  prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          primed_q, primed_d;
   logic          upd_q, upd_d;

   // s3_q is the previous synced value; a change there restarts the filter window
   always_comb begin
      cnt_d    = '0;
      filt_d   = filt_q;
      prev_d   = prev_q;
      primed_d = primed_q;
      upd_d    = 1'b0;
      if (((s2_q != filt_q) || !primed_q) && (s2_q == s3_q)) begin
         if (cnt_q == LAST) begin
            filt_d   = s2_q;
            prev_d   = filt_q;
            primed_d = 1'b1;
            upd_d    = primed_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         filt_q   <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         primed_q <= !PRIME;
         upd_q    <= 1'b0;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         filt_q   <= filt_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
         upd_q    <= upd_d;
      end
   end

   assign filt_o = filt_q;
   assign prev_o = prev_q;
   assign upd_o  = upd_q;
endmodule

module quad_encoder_decoder #(
   parameter int CNT_W      = 16,
   parameter int DEB_CYCLES = 1_000_000,
   parameter int RES        = 4,
   parameter int SATURATE   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enc_a,
   input  logic                    enc_b,
   input  logic                    enc_btn,
   input  logic                    clr,
   input  logic                    load,
   input  logic signed [CNT_W-1:0] load_val,
   input  logic                    err_clr,
   output logic signed [CNT_W-1:0] count,
   output logic                    dir,
   output logic                    step,
   output logic                    err,
   output logic                    btn_db,
   output logic                    btn_press
);
   localparam int RES_EFF = (RES == 1 || RES == 2) ? RES : 4;
   localparam logic signed [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic signed [CNT_W-1:0] CMIN = {1'b1, {(CNT_W-1){1'b0}}};

   logic [1:0] ab_filt, ab_prev;
   logic       ab_upd;
   logic       btn_filt, btn_prev, btn_upd;

   qed_debounce #(.W(2), .DEB_CYCLES(DEB_CYCLES), .PRIME(1'b1)) u_ab (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  ({enc_a, enc_b}),
      .filt_o (ab_filt),
      .prev_o (ab_prev),
      .upd_o  (ab_upd)
   );

   qed_debounce #(.W(1), .DEB_CYCLES(DEB_CYCLES), .PRIME(1'b0)) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (enc_btn),
      .filt_o (btn_filt),
      .prev_o (btn_prev),
      .upd_o  (btn_upd)
   );

   logic [3:0]              trans;
   logic                    fwd, rev, ill;
   logic                    fwd_cnt, rev_cnt;
   logic signed [CNT_W-1:0] count_q, count_d, stepped;
   logic                    dir_q, dir_d;
   logic                    step_q, step_d;
   logic                    err_q, err_d;

   assign trans = {ab_prev, ab_filt};

   always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      ill = 1'b0;
      if (ab_upd) begin
         case (trans)
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: ill = 1'b1;
            default: ;
         endcase
      end
   end

   // Lower resolutions count only on the gray edges nearest the 00 detent
   assign fwd_cnt = fwd && ((RES_EFF == 4) || (trans == 4'b1000) ||
                            ((RES_EFF == 2) && (trans == 4'b0111)));
   assign rev_cnt = rev && ((RES_EFF == 4) || (trans == 4'b0010) ||
                            ((RES_EFF == 2) && (trans == 4'b1101)));

   always_comb begin
      stepped = count_q;
      if (fwd_cnt) begin
         stepped = ((SATURATE != 0) && (count_q == CMAX)) ? count_q : count_q + 1'b1;
      end else if (rev_cnt) begin
         stepped = ((SATURATE != 0) && (count_q == CMIN)) ? count_q : count_q - 1'b1;
      end
      if (clr)       count_d = '0;
      else if (load) count_d = load_val;
      else           count_d = stepped;
      step_d = fwd_cnt | rev_cnt;
      dir_d  = fwd_cnt ? 1'b1 : (rev_cnt ? 1'b0 : dir_q);
      err_d  = ill ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         err_q   <= err_d;
      end
   end

   assign count     = count_q;
   assign dir       = dir_q;
   assign step      = step_q;
   assign err       = err_q;
   assign btn_db    = btn_filt;
   // upd is high only in the first cycle of a new filtered level
   assign btn_press = btn_upd & btn_filt & ~btn_prev;
endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Directed bench: five encoder instances (x4, x1, x2, 4-bit wrap, 4-bit saturate) share the pins.

module tb_quad_encoder_decoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enc_a = 1'b0, enc_b = 1'b0, enc_btn = 1'b0, err_clr = 1'b0;
   logic clr16 = 1'b0, load16 = 1'b0, clr4 = 1'b0, load4 = 1'b0;
   logic signed [15:0] lv16 = '0;
   logic signed [3:0]  lv4 = '0;

   logic signed [15:0] c4, c1, c2;
   logic signed [3:0]  cw, cs;
   logic d4, s4, e4, bd4, bp4;
   logic d1, s1, e1, bd1, bp1;
   logic d2, s2, e2, bd2, bp2;
   logic dw, sw, ew, bdw, bpw;
   logic ds, ss, es, bds, bps;

   int checks = 0;
   int errors = 0;
   int n_step4 = 0, n_steps = 0, n_press = 0;
   int ns0, nst;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (s4)  n_step4 <= n_step4 + 1;
      if (ss)  n_steps <= n_steps + 1;
      if (bp4) n_press <= n_press + 1;
   end

   quad_encoder_decoder #(.CNT_W(16), .DEB_CYCLES(4), .RES(4), .SATURATE(0)) u4 (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
      .clr(clr16), .load(load16), .load_val(lv16), .err_clr(err_clr),
      .count(c4), .dir(d4), .step(s4), .err(e4), .btn_db(bd4), .btn_press(bp4));
   quad_encoder_decoder #(.CNT_W(16), .DEB_CYCLES(4), .RES(1), .SATURATE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
      .clr(clr16), .load(load16), .load_val(lv16), .err_clr(err_clr),
      .count(c1), .dir(d1), .step(s1), .err(e1), .btn_db(bd1), .btn_press(bp1));
   quad_encoder_decoder #(.CNT_W(16), .DEB_CYCLES(4), .RES(2), .SATURATE(0)) u2 (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
      .clr(clr16), .load(load16), .load_val(lv16), .err_clr(err_clr),
      .count(c2), .dir(d2), .step(s2), .err(e2), .btn_db(bd2), .btn_press(bp2));
   quad_encoder_decoder #(.CNT_W(4), .DEB_CYCLES(4), .RES(4), .SATURATE(0)) uw (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
      .clr(clr4), .load(load4), .load_val(lv4), .err_clr(err_clr),
      .count(cw), .dir(dw), .step(sw), .err(ew), .btn_db(bdw), .btn_press(bpw));
   quad_encoder_decoder #(.CNT_W(4), .DEB_CYCLES(4), .RES(4), .SATURATE(1)) us (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
      .clr(clr4), .load(load4), .load_val(lv4), .err_clr(err_clr),
      .count(cs), .dir(ds), .step(ss), .err(es), .btn_db(bds), .btn_press(bps));

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic move(input logic [1:0] ab, input int n);
      @(negedge clk);
      enc_a = ab[1];
      enc_b = ab[0];
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Change pins, then stop 1 time unit after edge 6 (the decode lands on edge 7)
   task automatic move_to_e6(input logic [1:0] ab);
      @(negedge clk);
      enc_a = ab[1];
      enc_b = ab[0];
      @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", c4, 0);
      chk("rst_dir", d4, 0);
      chk("rst_step", s4, 0);
      chk("rst_err", e4, 0);
      chk("rst_btn_db", bd4, 0);
      chk("rst_btn_press", bp4, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("prime00_count", c4, 0);
      chk("prime00_nostep", n_step4, 0);
      chk("prime00_err", e4, 0);

      // forward x4 with exact latency
      move_to_e6(2'b01);
      chk("lat_e6_step", s4, 0);
      chk("lat_e6_count", c4, 0);
      @(posedge clk); #1;
      chk("lat_e7_step", s4, 1);
      chk("lat_e7_count", c4, 1);
      chk("lat_e7_dir", d4, 1);
      @(posedge clk); #1;
      chk("step_one_cycle", s4, 0);
      repeat (2) @(posedge clk);
      move(2'b11, 10);
      move(2'b10, 10);
      move(2'b00, 10);
      chk("fwd_x4_count", c4, 4);
      chk("fwd_x4_dir", d4, 1);
      chk("fwd_x4_steps", n_step4, 4);
      chk("fwd_x1_count", c1, 1);
      chk("fwd_x2_count", c2, 2);
      chk("fwd_err", e4, 0);

      @(negedge clk) clr16 = 1'b1;
      @(negedge clk) clr16 = 1'b0;
      @(posedge clk); #1;
      chk("clr_count", c4, 0);
      chk("clr_x1", c1, 0);

      // reverse
      move(2'b10, 10);
      move(2'b11, 10);
      move(2'b01, 10);
      move(2'b00, 10);
      chk("rev_x4_count", c4, -4);
      chk("rev_x1_count", c1, -1);
      chk("rev_x2_count", c2, -2);
      chk("rev_x1_dir", d1, 0);
      chk("rev_x2_dir", d2, 0);
      chk("rev_x4_steps", n_step4, 8);

      // short A glitch is filtered
      @(negedge clk) enc_a = 1'b1;
      repeat (3) @(negedge clk);
      enc_a = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("glitch_count", c4, -4);
      chk("glitch_steps", n_step4, 8);

      // button bounce then hold
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         enc_btn = (i % 2 == 0);
         @(negedge clk);
      end
      @(negedge clk) enc_btn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("btn_db_high", bd4, 1);
      chk("btn_press_once", n_press, 1);
      @(negedge clk) enc_btn = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("btn_db_low", bd4, 0);
      chk("btn_release_nopulse", n_press, 1);

      // illegal transitions
      move(2'b11, 10);
      chk("ill_err", e4, 1);
      chk("ill_count", c4, -4);
      chk("ill_dir", d4, 0);
      chk("ill_steps", n_step4, 8);
      move_to_e6(2'b00);
      @(negedge clk) err_clr = 1'b1;
      @(posedge clk); #1;
      chk("ill_set_wins", e4, 1);
      @(posedge clk); #1;
      chk("err_clr_alone", e4, 0);
      err_clr = 1'b0;
      chk("ill2_count", c4, -4);

      // 4-bit wrap / saturate
      @(negedge clk) begin lv4 = 4'sd7; load4 = 1'b1; end
      @(negedge clk) load4 = 1'b0;
      @(posedge clk); #1;
      chk("load7_wrap", cw, 7);
      chk("load7_sat", cs, 7);
      ns0 = n_steps;
      move(2'b01, 10);
      chk("wrap_max", cw, -8);
      chk("sat_max", cs, 7);
      chk("sat_max_step", n_steps, ns0 + 1);
      chk("sat_max_dir", ds, 1);
      @(negedge clk) begin lv4 = -4'sd8; load4 = 1'b1; end
      @(negedge clk) load4 = 1'b0;
      @(posedge clk); #1;
      chk("loadm8_sat", cs, -8);
      move(2'b00, 10);
      chk("wrap_min", cw, 7);
      chk("sat_min", cs, -8);
      chk("sat_min_step", n_steps, ns0 + 2);
      chk("sat_min_dir", ds, 0);

      // clr coincident with a forward step
      move_to_e6(2'b01);
      @(negedge clk) clr16 = 1'b1;
      @(posedge clk); #1;
      chk("clrstep_count", c4, 0);
      chk("clrstep_step", s4, 1);
      chk("clrstep_dir", d4, 1);
      @(negedge clk) clr16 = 1'b0;

      // reset mid-rotation
      enc_btn = 1'b1;
      move(2'b11, 15);
      chk("pre_rst_count", c4, 1);
      chk("pre_rst_btn", bd4, 1);
      chk("pre_rst_press", n_press, 2);
      move(2'b10, 3);
      @(negedge clk) rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_count", c4, 0);
      chk("midrst_dir", d4, 0);
      chk("midrst_step", s4, 0);
      chk("midrst_err", e4, 0);
      chk("midrst_btn_db", bd4, 0);
      chk("midrst_btn_press", bp4, 0);
      nst = n_step4;
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("reprime_count", c4, 0);
      chk("reprime_nostep", n_step4, nst);
      chk("reprime_err", e4, 0);
      move(2'b00, 10);
      chk("post_prime_count", c4, 1);
      chk("post_prime_dir", d4, 1);
      chk("post_rst_btn", bd4, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/quad_encoder_decoder.md
Name: quad_encoder_decoder

Overview:
Parametrised quadrature-encoder front end for the panel and LED demo designs. It synchronises and debounces the A/B/button pins and decodes gray-code transitions at x1, x2 or x4 resolution into a signed position counter. The counter is wide and loadable, and can wrap or saturate. The block also provides a direction flag, a step strobe, illegal-transition detection and a debounced button with a press strobe. It sits between the board pins and the display/control logic.

Parameters:
CNT_W, 16, position counter width (bits, two's complement), 2..32
DEB_CYCLES, 1_000_000, consecutive stable clk cycles before a filtered input changes (20 ms at 50 MHz); must be >= 1
RES, 4, decode resolution: 1, 2 or 4 counts per gray cycle; any other value behaves as 4
SATURATE, 0, 0 = count wraps modulo 2^CNT_W; 1 = count clamps at signed max/min

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
enc_a  in  1  encoder phase A, asynchronous
enc_b  in  1  encoder phase B, asynchronous
enc_btn  in  1  encoder push button, asynchronous, active-high
clr  in  1  synchronous clear of count
load  in  1  synchronous load of count from load_val
load_val  in  CNT_W  preload value, signed
err_clr  in  1  clears err
count  out  CNT_W  signed position
dir  out  1  direction of last counted step: 1 = forward, 0 = reverse
step  out  1  one-cycle pulse for each counted step
err  out  1  sticky illegal-transition flag
btn_db  out  1  debounced button level
btn_press  out  1  one-cycle pulse on debounced rising edge of the button

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - count=0, dir=0, step=0, err=0, btn_db=0, btn_press=0.
  - Synchroniser flops=0, filtered AB=00, debounce counters=0, primed=0.
- Synchroniser: every input passes through 2 flops before the debounce stage.
- Debounce: one independent filter per input (A, B, button).
  - The counter increments while the synced value differs from the filtered value (AB filter: also while primed=0).
  - The counter returns to 0 whenever the synced value changes or equals the filtered value.
  - When the counter reaches DEB_CYCLES-1 and the input still differs, the filtered value updates on that edge.
  - A and B are filtered jointly as a 2-bit word: any change in either bit restarts the AB counter.
- Priming: the first AB filter update after reset loads the filtered state and sets primed=1, with no count, step or err. If the pins sit at 00, priming still occurs after DEB_CYCLES stable cycles.
- Gray decode, previous -> new filtered AB, applied one clk after the filtered update:
  - Forward: 00->01->11->10->00. Reverse: 00->10->11->01->00.
  - RES=4: every legal transition counts +/-1.
  - RES=2: forward counts on 01->11 and 10->00; reverse counts on 11->01 and 00->10.
  - RES=1: forward counts on 10->00; reverse counts on 00->10.
  - Non-counting legal transitions update the state only.
- Illegal transition (both bits change, e.g. 00->11): err<=1, no count, no step, dir unchanged, state updates to the new value.
- Latency: a clean pin change held stable is reflected in count, step and dir exactly DEB_CYCLES+3 clk edges after the first edge at which the pin is sampled changed.
- Count priority: rst_n > clr > load > decoded step.
  - On clr or load, step and dir still reflect a simultaneous decoded step, but count takes 0 or load_val.
- Arithmetic:
  - SATURATE=0: signed max+1 wraps to signed min, and min-1 wraps to max.
  - SATURATE=1: count holds at max/min; step and dir are still issued.
- err: set by an illegal transition; cleared by err_clr. If both happen in the same cycle, set wins.
- Button: btn_press=1 for exactly one cycle when btn_db goes 0->1. Release produces no pulse.

Test Plan:
- DEB_CYCLES=4, RES=4: after priming at AB=00, drive 00->01->11->10->00 with each state held 10 cycles -> count 0,1,2,3,4, step pulses 4 times, dir=1; the first step appears exactly 7 edges after the pin change.
- Same sequence reversed, RES=1 then RES=2 -> count -1 and -2 respectively, dir=0.
- Glitch A for 3 cycles (< DEB_CYCLES) -> no count change, no step; button bounce 1-0-1 every 2 cycles, then held 1 -> a single btn_press pulse.
- Jump AB 00->11, held -> err=1, count unchanged; err_clr asserted together with a second illegal jump -> err stays 1; err_clr alone -> err=0.
- CNT_W=4: SATURATE=0, load_val=7 plus 1 forward step -> count=-8; SATURATE=1, load 7 plus forward step -> 7 with step=1; load -8 plus reverse step -> -8.
- Assert clr on the same cycle as a decoded forward step -> count=0, step=1, dir=1; rst_n=0 mid-rotation -> all outputs 0, and the first post-reset filtered value primes without count.
